// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a three-state controller (IDLE/BUSY/DONE).
// Single-cycle ops (logic, add/sub, slt, shifts) finish one cycle after
// acceptance. MUL (shift-add) and DIVU (restoring) iterate WIDTH cycles.
// Optional macro: ALU_MC_DIV_EN builds the divider. When it is undefined,
// opcode 1001 is handled as an undefined opcode.
// Ports:
//   Clock, Reset      - clock, synchronous active-high reset
//   Start             - request an operation (accepted when Ready=1)
//   A, B, AInvert, Op - operands, A-invert for logic ops, opcode
//   Ready             - controller idle, Start will be accepted
//   Done              - one-cycle pulse, Result and flags valid
//   Result            - registered result
//   Zero, Overflow, CarryOut - registered flags
module alu_mc #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             AInvert,
    input  logic [3:0]       Op,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             CarryOut
);

    localparam int unsigned SH_W = $clog2(WIDTH);
    localparam int unsigned W1   = WIDTH + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b1100;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1001;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;       // MUL: product high half, DIVU: remainder
    logic [WIDTH-1:0]  lo_q, lo_d;       // MUL: multiplier/product low, DIVU: dividend/quotient
    logic [WIDTH-1:0]  mcand_q, mcand_d; // MUL: multiplicand, DIVU: divisor
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic              cout_q, cout_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
`ifdef ALU_MC_DIV_EN
    logic              is_div_q, is_div_d;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_trial;
`endif

    logic [WIDTH-1:0]  a_log;
    logic [WIDTH:0]    add_full;
    logic [WIDTH:0]    sub_full;
    logic              add_ovf;
    logic              sub_ovf;
    logic [SH_W-1:0]   shamt;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_cout;
    logic              alu_ovf;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  step_hi;
    logic [WIDTH-1:0]  step_lo;

    // Single-cycle datapath, evaluated on the live inputs at acceptance.
    always_comb begin : alu_single
        a_log    = AInvert ? ~A : A;
        add_full = {1'b0, A} + {1'b0, B};
        sub_full = {1'b0, A} + {1'b0, ~B} + W1'(1);
        add_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
        sub_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_full[WIDTH-1] != A[WIDTH-1]);
        shamt    = B[SH_W-1:0];
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (Op)
            OP_AND: alu_res = a_log & B;
            OP_OR:  alu_res = a_log | B;
            OP_XOR: alu_res = a_log ^ B;
            OP_ADD: begin
                alu_res  = add_full[WIDTH-1:0];
                alu_cout = add_full[WIDTH];
                alu_ovf  = add_ovf;
            end
            OP_SUB: begin
                alu_res  = sub_full[WIDTH-1:0];
                alu_cout = sub_full[WIDTH];
                alu_ovf  = sub_ovf;
            end
            // Sign of A-B corrected by overflow gives the true signed compare.
            OP_SLT: alu_res = WIDTH'(sub_full[WIDTH-1] ^ sub_ovf);
            OP_SLL: alu_res = A << shamt;
            OP_SRA: alu_res = WIDTH'($signed(A) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // One iteration of the shift-add multiplier or restoring divider.
    always_comb begin : iter_step
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : W1'(0));
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, mcand_q};
        if (is_div_q) begin
            if (!div_trial[WIDTH]) begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Controller next state and registered-output next values.
    always_comb begin : next_state
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        cout_d   = cout_q;
`ifdef ALU_MC_DIV_EN
        is_div_d = is_div_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (Op == OP_MUL) begin
                        state_d = S_BUSY;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = B;
                        mcand_d = A;
`ifdef ALU_MC_DIV_EN
                        is_div_d = 1'b0;
                    end else if (Op == OP_DIVU) begin
                        state_d  = S_BUSY;
                        cnt_d    = '0;
                        hi_d     = '0;
                        lo_d     = A;
                        mcand_d  = B;
                        is_div_d = 1'b1;
`endif
                    end else begin
                        state_d  = S_DONE;
                        result_d = alu_res;
                        ovf_d    = alu_ovf;
                        cout_d   = alu_cout;
                    end
                end
            end
            S_BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + SH_W'(1);
                // The last iteration's edge also enters DONE with the final values.
                if (cnt_q == SH_W'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    result_d = step_lo;
                    ovf_d    = |step_hi;
                    cout_d   = 1'b0;
`ifdef ALU_MC_DIV_EN
                    if (is_div_q) begin
                        ovf_d = (mcand_q == '0);
                        if (mcand_q == '0) begin
                            result_d = '1;
                        end
                    end
`endif
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // state_d is DONE only on entry, so the flag follows the new result.
        if (state_d == S_DONE) begin
            zero_d = (result_d == '0);
        end
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
`ifdef ALU_MC_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
`ifdef ALU_MC_DIV_EN
            is_div_q <= is_div_d;
`endif
        end
    end

    assign Ready    = ready_q;
    assign Done     = done_q;
    assign Result   = result_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;
    assign CarryOut = cout_q;

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, datapath width; legal values are powers of two from 4 to 64.
REQ-002 The block SHALL have port Clock  input  1  sole clock; all state changes on rising edge.
REQ-003 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port Start  input  1  request to begin an operation.
REQ-005 The block SHALL have port A  input  WIDTH  operand A.
REQ-006 The block SHALL have port B  input  WIDTH  operand B.
REQ-007 The block SHALL have port AInvert  input  1  invert A before logic ops.
REQ-008 The block SHALL have port Op  input  4  opcode.
REQ-009 The block SHALL have port Ready  output  1  high when a Start will be accepted.
REQ-010 The block SHALL have port Done  output  1  one-cycle pulse, result valid.
REQ-011 The block SHALL have port Result  output  WIDTH  registered result.
REQ-012 The block SHALL have ports Zero, Overflow and CarryOut  output  1 each  registered flags.

Function
REQ-013 Acceptance SHALL occur on a rising edge with Start=1 and Ready=1; A, B, AInvert and Op are captured then, and later input changes SHALL NOT affect the operation.
REQ-014 The FSM SHALL have three states: IDLE (Ready=1), BUSY (Ready=0), DONE (Ready=0, Done=1); DONE SHALL always go to IDLE on the next edge.
REQ-015 Single-cycle ops SHALL go IDLE->DONE on acceptance, so Done is high the cycle after acceptance.
REQ-016 MUL and DIVU SHALL go IDLE->BUSY, iterate exactly WIDTH cycles, then go to DONE; Done is high WIDTH+1 cycles after acceptance.
REQ-017 Start while not Ready SHALL be ignored, with no queuing.
REQ-018 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 XOR (each using A or ~A per AInvert); 0100 ADD; 1100 SUB (A+~B+1); 1101 SLT; 0110 SLL; 0111 SRA; 1000 MUL; 1001 DIVU.
REQ-019 AInvert SHALL apply only to AND/OR/XOR.
REQ-020 ADD/SUB: CarryOut SHALL be the carry out of the MSB (SUB: 1 = no borrow); Overflow SHALL be the signed two's-complement overflow.
REQ-021 SLT SHALL yield Result=1 if signed A<B, else 0, and SHALL be correct even when A-B overflows.
REQ-022 SLL/SRA shift amount SHALL be B[log2(WIDTH)-1:0]; SRA SHALL replicate A[WIDTH-1].
REQ-023 MUL SHALL be unsigned shift-add; Result = low WIDTH bits of the product; Overflow=1 if the high WIDTH bits are nonzero.
REQ-024 DIVU SHALL be an unsigned restoring divide; Result = quotient.
REQ-025 DIVU with B=0 SHALL give Result = all ones and Overflow=1.
REQ-026 CarryOut and Overflow SHALL be 0 for every op not listed in REQ-020, REQ-023 or REQ-025.
REQ-027 Zero SHALL equal (Result==0) for every op.
REQ-028 Undefined opcodes SHALL complete as single-cycle ops with Result=0, Zero=1, Overflow=0, CarryOut=0.
REQ-029 Result and the flags SHALL update only on entry to DONE and hold until the next DONE.

Reset
REQ-030 Reset SHALL force IDLE and clear Result, Zero, Overflow, CarryOut, Done and iteration state to 0; Ready SHALL be 1 the cycle after Reset.
REQ-031 Reset during BUSY SHALL abort the operation with no Done pulse; Reset has priority over Start.

Configuration
REQ-032 The macro ALU_MC_DIV_EN SHALL control the divider. Defined: DIVU is implemented per REQ-024 and REQ-025. Undefined: no divider logic is built and 1001 SHALL behave as an undefined opcode per REQ-028.

Verification
REQ-033 The bench SHALL cover, with WIDTH=16: ADD A=10, B=10 -> Result=20, Zero=0, Done one cycle after accept; SUB A=10, B=10 -> Result=0, Zero=1, CarryOut=1.
REQ-034 The bench SHALL cover: ADD A=0x7FFF, B=1 -> Result=0x8000, Overflow=1, CarryOut=0; SLT A=0x8000, B=1 -> Result=1.
REQ-035 The bench SHALL cover: MUL A=300, B=300 -> Result=0x5F90, Overflow=1, Done exactly 17 cycles after accept, Ready=0 throughout, and a Start pulse mid-operation ignored.
REQ-036 The bench SHALL cover, with ALU_MC_DIV_EN: DIVU A=100, B=7 -> Result=14; DIVU B=0 -> Result=0xFFFF, Overflow=1. Without the macro: Op=1001 -> Result=0, Done after 1 cycle.
REQ-037 The bench SHALL cover: Reset asserted at cycle 5 of a MUL -> no Done, all outputs 0, Ready=1 next cycle, and a following ADD 3+4 -> 7.
REQ-038 The bench SHALL cover: SRA A=0x8000, B=0x0013 (shift 3) -> Result=0xF000; AND with AInvert=1, A=0x00FF, B=0x0F0F -> Result=0x0F00.
